// File: rtl/memory_unit_if.sv
// Control/status handshake between the processor sequencer and the memory unit.
// The shared data bus is a tristate net and stays a plain inout port on the unit.
interface memory_unit_if;
  logic mar_in;   // load MAR from bus
  logic mbr_in;   // load MBR from bus
  logic mbr_out;  // drive MBR onto bus
  logic rnw;      // 1 = read, 0 = write; sampled with mem_req
  logic mem_req;  // start an access
  logic MFC;      // memory function complete, one-cycle pulse
  logic busy;     // access in flight

  modport master (
    output mar_in, mbr_in, mbr_out, rnw, mem_req,
    input  MFC, busy
  );

  modport slave (
    input  mar_in, mbr_in, mbr_out, rnw, mem_req,
    output MFC, busy
  );
endinterface

// File: rtl/memory_unit.sv
// Bus-attached memory with MAR/MBR registers and a fixed wait-state access FSM.
// Handshake: mem_req is sampled at a rising edge while not busy; the access
// completes WAIT_CYCLES+1 edges later and MFC is high for exactly the one
// DONE cycle that follows. Inputs other than mbr_out are ignored while busy.
// DEPTH must be 2..256; addresses at or above DEPTH read 0 and drop writes.
module memory_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  inout  wire  [7:0]   bus,
  memory_unit_if.slave ctl,
  output logic [1:0]   dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          rnw_q;
  logic [7:0]    mar;
  logic [7:0]    mbr;
  logic [7:0]    acc_addr;  // MAR captured when the request was accepted
  logic [7:0]    acc_data;  // MBR captured when the request was accepted
  logic          mfc_q;
  logic          busy_q;
  logic [7:0]    mem [DEPTH];

  logic          in_range;
  logic [AW-1:0] idx;
  logic          complete;

  assign in_range = (32'(acc_addr) < DEPTH);
  assign idx      = AW'(acc_addr);
  assign complete = (state == BUSY) && (cnt == 4'd0);

  // MBR goes onto the bus only on request and never while reset is held.
  assign bus = (ctl.mbr_out && reset_n) ? mbr : 8'hzz;

  assign ctl.MFC   = mfc_q;
  assign ctl.busy  = busy_q;
  assign dbg_state = state;

  // Access FSM plus MAR/MBR registers; the access works on the values
  // captured at acceptance, so same-edge MAR/MBR loads do not affect it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rnw_q    <= 1'b1;
      mar      <= 8'h00;
      mbr      <= 8'h00;
      acc_addr <= 8'h00;
      acc_data <= 8'h00;
      mfc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mfc_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctl.mar_in) mar <= bus;
          if (ctl.mbr_in) mbr <= bus;
          if (ctl.mem_req) begin
            state    <= BUSY;
            busy_q   <= 1'b1;
            cnt      <= 4'(WAIT_CYCLES);
            rnw_q    <= ctl.rnw;
            acc_addr <= mar;
            acc_data <= mbr;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            mfc_q  <= 1'b1;
            if (rnw_q) mbr <= in_range ? mem[idx] : 8'h00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage write on the completion edge; contents survive reset.
  always_ff @(posedge clock) begin
    if (reset_n && complete && !rnw_q && in_range) mem[idx] <= acc_data;
  end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: one instance with default parameters and
// one with WAIT_CYCLES=0, DEPTH=16. Expected MFC cycles and bus values are
// queued by the drivers and consumed by the monitor.
module tb_memory_unit;

  localparam int W0 = 2;
  localparam int W1 = 0;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // stimulus signals, index 0 = dut0, 1 = dut1
  logic [1:0] mar_in_v  = '0;
  logic [1:0] mbr_in_v  = '0;
  logic [1:0] mbr_out_v = '0;
  logic [1:0] rnw_v     = '0;
  logic [1:0] req_v     = '0;
  logic [1:0] pc_en     = '0;
  logic [1:0] rd_flag   = '0;
  logic [7:0] pc_val [2];

  wire  [7:0] bus0;
  wire  [7:0] bus1;
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  // program counter drivers sharing each bus
  assign bus0 = pc_en[0] ? pc_val[0] : 8'hzz;
  assign bus1 = pc_en[1] ? pc_val[1] : 8'hzz;

  memory_unit_if u_if0 ();
  memory_unit_if u_if1 ();

  assign u_if0.mar_in  = mar_in_v[0];
  assign u_if0.mbr_in  = mbr_in_v[0];
  assign u_if0.mbr_out = mbr_out_v[0];
  assign u_if0.rnw     = rnw_v[0];
  assign u_if0.mem_req = req_v[0];
  assign u_if1.mar_in  = mar_in_v[1];
  assign u_if1.mbr_in  = mbr_in_v[1];
  assign u_if1.mbr_out = mbr_out_v[1];
  assign u_if1.rnw     = rnw_v[1];
  assign u_if1.mem_req = req_v[1];

  memory_unit #(.WAIT_CYCLES(W0), .DEPTH(256)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0), .ctl(u_if0.slave), .dbg_state(dbg0)
  );

  memory_unit #(.WAIT_CYCLES(W1), .DEPTH(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1), .ctl(u_if1.slave), .dbg_state(dbg1)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q0 [$];   // expected MFC cycle, dut0
  logic [31:0] exp_q1 [$];   // expected MFC cycle, dut1
  logic [7:0]  dat_q0 [$];   // expected bus value, dut0
  logic [7:0]  dat_q1 [$];   // expected bus value, dut1

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // monitor: samples on the falling edge, away from input changes
  always @(negedge clock) begin
    if (reset_n) begin
      if (u_if0.MFC) begin
        if (exp_q0.size() == 0) spurious("mfc0_spurious");
        else check("mfc0_cycle", cyc, exp_q0.pop_front());
      end
      if (u_if1.MFC) begin
        if (exp_q1.size() == 0) spurious("mfc1_spurious");
        else check("mfc1_cycle", cyc, exp_q1.pop_front());
      end
      if (rd_flag[0]) begin
        if (dat_q0.size() == 0) spurious("bus0_spurious");
        else check("bus0_value", {24'h0, bus0}, {24'h0, dat_q0.pop_front()});
      end
      if (rd_flag[1]) begin
        if (dat_q1.size() == 0) spurious("bus1_spurious");
        else check("bus1_value", {24'h0, bus1}, {24'h0, dat_q1.pop_front()});
      end
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_mfc(input int s, input int extra);
    if (s == 0) exp_q0.push_back(32'(cyc + W0 + 2 + extra));
    else        exp_q1.push_back(32'(cyc + W1 + 2 + extra));
  endtask

  task automatic load_mar(input int s, input logic [7:0] v);
    pc_en[s] = 1'b1; pc_val[s] = v; mar_in_v[s] = 1'b1;
    tick();
    pc_en[s] = 1'b0; mar_in_v[s] = 1'b0;
  endtask

  task automatic load_mbr(input int s, input logic [7:0] v);
    pc_en[s] = 1'b1; pc_val[s] = v; mbr_in_v[s] = 1'b1;
    tick();
    pc_en[s] = 1'b0; mbr_in_v[s] = 1'b0;
  endtask

  task automatic observe(input int s, input logic drv, input logic [7:0] pcv,
                         input logic out, input logic [7:0] exp);
    pc_en[s] = drv; pc_val[s] = pcv; mbr_out_v[s] = out; rd_flag[s] = 1'b1;
    if (s == 0) dat_q0.push_back(exp);
    else        dat_q1.push_back(exp);
    tick();
    pc_en[s] = 1'b0; mbr_out_v[s] = 1'b0; rd_flag[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (((s == 0) ? dbg0 : dbg1) == 2'd0) done = 1'b1;
      else tick();
    end
    if (!done) spurious("wait_idle_timeout");
  endtask

  task automatic request(input int s, input logic r);
    rnw_v[s] = r; req_v[s] = 1'b1;
    push_mfc(s, 0);
    tick();
    req_v[s] = 1'b0;
    wait_idle(s);
  endtask

  task automatic write_word(input int s, input logic [7:0] a, input logic [7:0] d);
    load_mar(s, a);
    load_mbr(s, d);
    request(s, 1'b0);
  endtask

  task automatic read_check(input int s, input logic [7:0] a, input logic [7:0] exp);
    load_mar(s, a);
    request(s, 1'b1);
    observe(s, 1'b0, 8'h00, 1'b1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    pc_val[0] = 8'h00;
    pc_val[1] = 8'h00;

    // reset state
    #3;
    check("rst_state0", {30'h0, dbg0}, 32'd0);
    check("rst_busy0", {31'h0, u_if0.busy}, 32'd0);
    check("rst_mfc0", {31'h0, u_if0.MFC}, 32'd0);
    check("rst_state1", {30'h0, dbg1}, 32'd0);
    check("rst_busy1", {31'h0, u_if1.busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    observe(0, 1'b0, 8'h00, 1'b1, 8'h00);
    observe(1, 1'b0, 8'h00, 1'b1, 8'h00);

    // bus sharing: PC value passes untouched while mbr_out is low
    observe(0, 1'b1, 8'h02, 1'b0, 8'h02);

    // write then read back
    write_word(0, 8'h01, 8'hA5);
    load_mbr(0, 8'h00);
    request(0, 1'b1);
    observe(0, 1'b0, 8'h00, 1'b1, 8'hA5);
    write_word(0, 8'h7F, 8'hE1);
    write_word(0, 8'h10, 8'h55);

    // mbr_in with mbr_out: MBR reloads itself
    load_mbr(0, 8'h3A);
    mbr_in_v[0] = 1'b1; mbr_out_v[0] = 1'b1;
    tick();
    mbr_in_v[0] = 1'b0; mbr_out_v[0] = 1'b0;
    observe(0, 1'b0, 8'h00, 1'b1, 8'h3A);

    // request with same-edge MAR load uses the old MAR
    load_mar(0, 8'h01);
    pc_en[0] = 1'b1; pc_val[0] = 8'h7F; mar_in_v[0] = 1'b1;
    rnw_v[0] = 1'b1; req_v[0] = 1'b1;
    push_mfc(0, 0);
    tick();
    pc_en[0] = 1'b0; mar_in_v[0] = 1'b0; req_v[0] = 1'b0;
    wait_idle(0);
    observe(0, 1'b0, 8'h00, 1'b1, 8'hA5);
    request(0, 1'b1);
    observe(0, 1'b0, 8'h00, 1'b1, 8'hE1);

    // busy lockout
    load_mar(0, 8'h01);
    rnw_v[0] = 1'b1; req_v[0] = 1'b1;
    push_mfc(0, 0);
    tick();
    pc_en[0] = 1'b1; pc_val[0] = 8'h7F; mar_in_v[0] = 1'b1;
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      if (u_if0.busy) bc++;
      tick();
      pc_en[0] = 1'b0; mar_in_v[0] = 1'b0; req_v[0] = 1'b0;
    end
    check("busy_cycles", 32'(bc), 32'd3);
    observe(0, 1'b0, 8'h00, 1'b1, 8'hA5);
    request(0, 1'b1);
    observe(0, 1'b0, 8'h00, 1'b1, 8'hA5);

    // back-to-back: second access starts straight from DONE
    rnw_v[0] = 1'b1; req_v[0] = 1'b1;
    push_mfc(0, 0);
    push_mfc(0, W0 + 2);
    repeat (5) tick();
    req_v[0] = 1'b0;
    wait_idle(0);

    // reset one cycle into a write of 0x3C to 0x10
    load_mar(0, 8'h10);
    load_mbr(0, 8'h3C);
    rnw_v[0] = 1'b0; req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    check("busy_before_abort", {31'h0, u_if0.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_state", {30'h0, dbg0}, 32'd0);
    check("abort_busy", {31'h0, u_if0.busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    observe(0, 1'b0, 8'h00, 1'b1, 8'h00);
    read_check(0, 8'h10, 8'h55);

    // zero wait states, DEPTH=16: out-of-range write dropped, no alias
    write_word(1, 8'h00, 8'h77);
    write_word(1, 8'h20, 8'h99);
    load_mbr(1, 8'h11);
    read_check(1, 8'h20, 8'h00);
    read_check(1, 8'h00, 8'h77);

    repeat (4) tick();
    check("mfc0_drained", exp_q0.size(), 32'd0);
    check("mfc1_drained", exp_q1.size(), 32'd0);
    check("dat0_drained", dat_q0.size(), 32'd0);
    check("dat1_drained", dat_q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving extra wait states per access; legal range 0..15.
REQ-002 SHALL have parameter DEPTH, default 256, giving the number of 8-bit words; addressed by the full 8-bit MAR.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port bus, inout, 8: shared processor bus, also driven by the program counter.
REQ-006 SHALL have port mar_in, input, 1: load MAR from bus.
REQ-007 SHALL have port mbr_in, input, 1: load MBR from bus.
REQ-008 SHALL have port mbr_out, input, 1: drive MBR onto bus.
REQ-009 SHALL have port rnw, input, 1: access type, 1 = read, 0 = write; sampled with mem_req.
REQ-010 SHALL have port mem_req, input, 1: start a memory access.
REQ-011 SHALL have port MFC, output, 1: memory function complete, a one-cycle pulse.
REQ-012 SHALL have port busy, output, 1: high while an access is in flight (BUSY state).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 IDLE or DONE, mem_req=1 at an edge: SHALL latch rnw, load wait counter with WAIT_CYCLES and go to BUSY.
REQ-015 BUSY: SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL perform the access and go to DONE.
REQ-016 Access latency: the access SHALL occur on edge E0+WAIT_CYCLES+1, where E0 is the request-sampling edge.
REQ-017 Read: MBR SHALL become mem[MAR] on the completion edge.
REQ-018 Write: mem[MAR] SHALL become MBR on the completion edge.
REQ-019 MFC SHALL be high for exactly the one cycle spent in DONE.
REQ-020 DONE: SHALL go to BUSY if mem_req=1 (back-to-back access), else to IDLE.
REQ-021 busy SHALL equal (state == BUSY).
REQ-022 mar_in=1 in IDLE or DONE: SHALL load MAR from bus at the edge.
REQ-023 mbr_in=1 in IDLE or DONE: SHALL load MBR from bus at the edge.
REQ-024 While busy, SHALL ignore mar_in, mbr_in and mem_req, leaving MAR, MBR and the access unchanged.
REQ-025 mem_req together with mar_in/mbr_in in the same IDLE/DONE edge: the access SHALL use the old MAR/MBR values; the loads still take effect.
REQ-026 bus SHALL be driven with MBR combinationally while mbr_out=1, and SHALL be high-Z otherwise, including during reset.
REQ-027 mbr_out and mbr_in both high: SHALL drive the bus with the old MBR and reload MBR with the same value, a net no-op.
REQ-028 MAR wraps naturally over 8 bits; addresses >= DEPTH SHALL read 0 and SHALL discard writes.
REQ-029 WAIT_CYCLES=0: the access SHALL complete on edge E0+1.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, MAR=0, MBR=0, MFC=0, busy=0, and bus high-Z.
REQ-031 Reset during BUSY SHALL abort the access: no memory write, and MBR stays 0.
REQ-032 Memory array contents SHALL NOT be cleared by reset.
REQ-033 Outputs SHALL be stable and valid from the first rising edge after reset_n deasserts.

Verification
REQ-034 Write then read, WAIT_CYCLES=2: bus=0x01 with mar_in; bus=0xA5 with mbr_in; mem_req, rnw=0 -> MFC pulses 3 edges after the request. Then mbr_in with 0x00, mem_req, rnw=1, then mbr_out -> bus reads 0xA5.
REQ-035 Busy lockout: during BUSY, pulse mar_in with bus=0x7F and mem_req -> MAR unchanged, exactly one MFC pulse, busy high for exactly 3 cycles.
REQ-036 Back-to-back: mem_req held high across DONE -> second access starts without an IDLE cycle; MFC pulses twice, spaced 4 cycles apart.
REQ-037 Reset mid-write: reset_n low one cycle into BUSY of a write of 0x3C to address 0x10 -> a later read of 0x10 returns its prior value, and MFC never pulses for the aborted access.
REQ-038 Bus sharing: mbr_out=0 -> bus is Z and a program counter driving 0x02 is observed unchanged; mbr_out=1 -> bus equals MBR.
REQ-039 Out-of-range address with DEPTH=16: write to MAR=0x20, then read 0x20 -> MBR=0x00, and no alias at 0x00.
